shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle controller for the ARM operand-2 shifter: decodes the 12-bit shifter operand,
//  sequences a 1-bit-per-cycle shift/rotate over Rm (or imm8), and returns result + shifter carry-out.
//  Sits between instruction decode and the ALU B input; start/busy/done handshake stalls the pipe.
//  Implements full ARM edge cases (LSR/ASR #32, RRX, register amounts >= 32) that a plain barrel mux omits.
// PARAMETERS
//  DATA_W   32  datapath width; only 32 is supported
//  CNT_W    6   shift-count register width; must hold 0..33
// PORTS
//  clk          in   1   rising-edge clock
//  reset_n      in   1   asynchronous active-low reset
//  start        in   1   request; accepted only when busy=0
//  flush        in   1   synchronous abort to IDLE, no done
//  op_imm       in   1   1 = immediate-rotate form, 0 = register-shift form
//  shifter_op   in   12  operand field: imm [11:8]=rot, [7:0]=imm8; reg [11:7]=shift_imm, [6:5]=type, [4]=by_reg
//  rm_value     in   32  value to shift (register form)
//  rs_value     in   8   register shift amount, Rs[7:0] (used when by_reg=1)
//  carry_in     in   1   CPSR C flag
//  busy         out  1   high from acceptance until the cycle done is asserted (inclusive of SHIFT)
//  done         out  1   one-cycle pulse; result/carry_out valid
//  result       out  32  shifted operand; held until next accepted start
//  carry_out    out  1   shifter carry-out; held with result
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; busy=0, done=0, result=0, carry_out=0, count=0. Mid-op reset discards the op.
//  - States: IDLE -> (start) LOAD-edge -> SHIFT (count>0) or DONE (count=0); SHIFT -> DONE when count hits 0;
//    DONE -> IDLE next cycle (done=1 only in DONE). The captured operands/type/count are latched at acceptance.
//  - Count/seed at acceptance (type 00 LSL, 01 LSR, 10 ASR, 11 ROR):
//    imm form: work=zext(imm8), type=ROR, count=2*rot; count=0 -> carry=carry_in.
//    reg, by_reg=0: count=shift_imm, except LSR#0/ASR#0 -> count=32; ROR#0 -> RRX (count=1, special op).
//    reg, by_reg=1: amt=rs_value; amt=0 -> count=0; LSL/LSR clamp count=min(amt,33); ASR clamp min(amt,32);
//    ROR: count=amt[4:0], but amt!=0 && amt[4:0]==0 -> count=32.
//  - Each SHIFT cycle: one-bit step of work; c_work takes the bit shifted out (LSL: bit31; LSR/ASR/ROR: bit0);
//    ASR refills bit31 with sign; ROR refills bit31 with bit0; RRX: work={carry_in,work[31:1]}, c=work[0]; count--.
//  - c_work initialised to carry_in at acceptance, so count=0 yields carry_out=carry_in.
//  - Latency: start edge to done-high cycle = max(count,0)+1 cycles (1 for count=0, 34 max for LSL/LSR by 33).
//  - result/carry_out update only on entry to DONE; unchanged during SHIFT.
//  - start while busy=1 (incl. DONE cycle): ignored, no queueing. start in the IDLE cycle after DONE is accepted.
//  - flush: highest priority after reset; any state -> IDLE next edge, busy=0, no done, result/carry_out keep old values.
//    flush and start same cycle in IDLE: flush wins, start dropped.
//  - No combinational path from inputs to outputs; all outputs registered.
// TESTING
//  1. imm: op_imm=1, shifter_op=12'h1FF, carry_in=0 -> result=32'hC000003F, carry_out=1, done 3 cycles after start.
//  2. LSL #0: shifter_op=12'h000, rm=32'h80000001, carry_in=0 -> result=32'h80000001, carry_out=0, done after 1 cycle.
//  3. LSR #0 (=LSR 32): shifter_op=12'h020, rm=32'h80000000 -> result=0, carry_out=1, latency 33.
//  4. by_reg: LSL rs=33, rm=32'hFFFFFFFF -> result=0, carry_out=0, latency 34; ASR rs=200, rm=32'h80000000 -> 32'hFFFFFFFF, C=1, latency 33.
//  5. RRX: shifter_op=12'h060, rm=32'h00000003, carry_in=1 -> result=32'h80000001, carry_out=1, latency 2; ROR rs=32, rm=32'h8000_0001 -> result unchanged, C=1.
//  6. Control: start during SHIFT ignored (one done only); flush at SHIFT cycle 5 -> IDLE, no done, result unchanged;
//     reset_n low mid-SHIFT -> all outputs 0 immediately (asynchronously); new start after release completes normally.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if
//   Handshake and operand bundle between instruction decode and the
//   operand-2 shift sequencer.
//   master : decode side, drives the request and operands and observes status/result.
//   slave  : sequencer side, consumes the request and returns status/result.
//   Signals:
//     start, flush        request and synchronous abort
//     op_imm, shifter_op  operand form and the 12-bit shifter operand field
//     rm_value, rs_value  value to shift and the register shift amount (Rs[7:0])
//     carry_in            current C flag
//     busy, done          sequencer status; done is a one-cycle pulse
//     result, carry_out   shifted operand and shifter carry-out
interface shift_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              flush;
  logic              op_imm;
  logic [11:0]       shifter_op;
  logic [DATA_W-1:0] rm_value;
  logic [7:0]        rs_value;
  logic              carry_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              carry_out;

  modport master (
    output start, flush, op_imm, shifter_op, rm_value, rs_value, carry_in,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, flush, op_imm, shifter_op, rm_value, rs_value, carry_in,
    output busy, done, result, carry_out
  );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle ARM operand-2 shifter. It decodes the 12-bit shifter operand
//   when a request is accepted, then shifts or rotates the captured value one
//   bit per cycle. It returns the result and the shifter carry-out with a
//   one-cycle done pulse. It covers the ARM edge cases: LSR/ASR #32, RRX, and
//   register amounts of 32 or more.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset; clears all state and outputs
//     bus      shift_sequencer_if.slave (start/flush/operands in, busy/done/result/carry_out out)
//   All outputs come straight from flops.
module shift_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  shift_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(6'd1);
  localparam logic [CNT_W-1:0] CNT_32   = CNT_W'(6'd32);
  localparam logic [CNT_W-1:0] CNT_33   = CNT_W'(6'd33);

  state_t            state_r;
  state_t            state_nx_s;

  logic [DATA_W-1:0] work_r;
  logic              c_work_r;
  logic [CNT_W-1:0]  count_r;
  logic [1:0]        type_r;
  logic              rrx_r;

  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] result_r;
  logic              carry_r;

  logic [DATA_W-1:0] seed_work_s;
  logic [1:0]        seed_type_s;
  logic [CNT_W-1:0]  seed_count_s;
  logic              seed_rrx_s;

  logic [DATA_W-1:0] step_work_s;
  logic              step_c_s;

  logic              accept_s;
  logic              last_step_s;
  logic              busy_nx_s;
  logic              done_nx_s;
  logic [DATA_W-1:0] result_nx_s;
  logic              carry_nx_s;

  // A request is only taken in IDLE, and flush takes priority over start.
  assign accept_s    = (state_r == ST_IDLE) && bus.start && !bus.flush;
  // The step in this cycle brings the count to zero.
  assign last_step_s = (state_r == ST_SHIFT) && !bus.flush && (count_r == CNT_ONE);

  // Operand decode: derive the initial work value, shift type and step count.
  always_comb begin
    seed_work_s  = bus.rm_value;
    seed_type_s  = bus.shifter_op[6:5];
    seed_count_s = CNT_ZERO;
    seed_rrx_s   = 1'b0;
    if (bus.op_imm) begin
      // Immediate form: rotate the zero-extended imm8 right by twice the rot field.
      seed_work_s  = {{(DATA_W-8){1'b0}}, bus.shifter_op[7:0]};
      seed_type_s  = SH_ROR;
      seed_count_s = CNT_W'({bus.shifter_op[11:8], 1'b0});
    end else if (bus.shifter_op[4]) begin
      // Register amount: zero means no shift. Larger amounts are clamped to
      // the point where the result stops changing.
      if (bus.rs_value == 8'd0) begin
        seed_count_s = CNT_ZERO;
      end else begin
        case (bus.shifter_op[6:5])
          SH_LSL, SH_LSR: seed_count_s = (bus.rs_value > 8'd33) ? CNT_33 : CNT_W'(bus.rs_value);
          SH_ASR:         seed_count_s = (bus.rs_value > 8'd32) ? CNT_32 : CNT_W'(bus.rs_value);
          SH_ROR:         seed_count_s = (bus.rs_value[4:0] == 5'd0) ? CNT_32
                                                                       : CNT_W'(bus.rs_value[4:0]);
          default:        seed_count_s = CNT_ZERO;
        endcase
      end
    end else begin
      // Immediate amount: #0 encodes LSR/ASR #32 and, for ROR, RRX.
      case (bus.shifter_op[6:5])
        SH_LSL: seed_count_s = CNT_W'(bus.shifter_op[11:7]);
        SH_LSR, SH_ASR: seed_count_s = (bus.shifter_op[11:7] == 5'd0) ? CNT_32
                                                                       : CNT_W'(bus.shifter_op[11:7]);
        SH_ROR: begin
          seed_count_s = (bus.shifter_op[11:7] == 5'd0) ? CNT_ONE : CNT_W'(bus.shifter_op[11:7]);
          seed_rrx_s   = (bus.shifter_op[11:7] == 5'd0);
        end
        default: seed_count_s = CNT_ZERO;
      endcase
    end
  end

  // One-bit step of the work register; the carry gets the bit shifted out.
  always_comb begin
    step_work_s = work_r;
    step_c_s    = c_work_r;
    if (rrx_r) begin
      step_work_s = {c_work_r, work_r[DATA_W-1:1]};
      step_c_s    = work_r[0];
    end else begin
      case (type_r)
        SH_LSL: begin
          step_work_s = {work_r[DATA_W-2:0], 1'b0};
          step_c_s    = work_r[DATA_W-1];
        end
        SH_LSR: begin
          step_work_s = {1'b0, work_r[DATA_W-1:1]};
          step_c_s    = work_r[0];
        end
        SH_ASR: begin
          step_work_s = {work_r[DATA_W-1], work_r[DATA_W-1:1]};
          step_c_s    = work_r[0];
        end
        SH_ROR: begin
          step_work_s = {work_r[0], work_r[DATA_W-1:1]};
          step_c_s    = work_r[0];
        end
        default: begin
          step_work_s = work_r;
          step_c_s    = c_work_r;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.flush) begin
          state_nx_s = ST_IDLE;
        end else if (bus.start) begin
          state_nx_s = (seed_count_s == CNT_ZERO) ? ST_DONE : ST_SHIFT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.flush) begin
          state_nx_s = ST_IDLE;
        end else if (count_r == CNT_ONE) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs.
  always_comb begin
    busy_nx_s   = (state_nx_s != ST_IDLE);
    done_nx_s   = (state_nx_s == ST_DONE);
    result_nx_s = result_r;
    carry_nx_s  = carry_r;
    if (accept_s && (seed_count_s == CNT_ZERO)) begin
      // A zero count passes the operand straight through with the incoming C flag.
      result_nx_s = seed_work_s;
      carry_nx_s  = bus.carry_in;
    end else if (last_step_s) begin
      result_nx_s = step_work_s;
      carry_nx_s  = step_c_s;
    end else begin
      result_nx_s = result_r;
      carry_nx_s  = carry_r;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {DATA_W{1'b0}};
      carry_r  <= 1'b0;
    end else begin
      busy_r   <= busy_nx_s;
      done_r   <= done_nx_s;
      result_r <= result_nx_s;
      carry_r  <= carry_nx_s;
    end
  end

  // Working datapath: capture at acceptance, then step once per SHIFT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_r   <= {DATA_W{1'b0}};
      c_work_r <= 1'b0;
      count_r  <= CNT_ZERO;
      type_r   <= SH_LSL;
      rrx_r    <= 1'b0;
    end else if (accept_s) begin
      work_r   <= seed_work_s;
      c_work_r <= bus.carry_in;
      count_r  <= seed_count_s;
      type_r   <= seed_type_s;
      rrx_r    <= seed_rrx_s;
    end else if ((state_r == ST_SHIFT) && !bus.flush) begin
      work_r   <= step_work_s;
      c_work_r <= step_c_s;
      count_r  <= count_r - CNT_ONE;
    end else begin
      work_r   <= work_r;
      c_work_r <= c_work_r;
      count_r  <= count_r;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.carry_out = carry_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
//   Scoreboard bench for shift_sequencer. Each request pushes an expected
//   result/carry/latency computed from ARM shifter semantics. The entry is
//   popped and compared when done is observed. Control cases cover ignored
//   starts, flush and asynchronous reset.
module tb_shift_sequencer;

  typedef struct {
    logic [31:0] result;
    logic        carry;
    int          lat;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ARM shifter result, carry and start-to-done latency in cycles.
  function automatic exp_t model(input bit imm, input logic [11:0] sop, input logic [31:0] rm,
                                 input logic [7:0] rs, input bit cin);
    exp_t        e;
    int          n;
    int          m;
    logic [31:0] v;
    logic [1:0]  ty;
    if (imm) begin
      n = 2 * int'(sop[11:8]);
      v = {24'd0, sop[7:0]};
      if (n == 0) begin
        e.result = v; e.carry = cin; e.lat = 1;
      end else begin
        e.result = (v >> n) | (v << (32 - n)); e.carry = e.result[31]; e.lat = n + 1;
      end
      return e;
    end
    ty = sop[6:5];
    if (sop[4]) n = int'(rs);
    else        n = int'(sop[11:7]);
    if (!sop[4] && n == 0) begin
      if (ty == 2'b11) begin
        e.result = {cin, rm[31:1]}; e.carry = rm[0]; e.lat = 2;
        return e;
      end
      if (ty != 2'b00) n = 32;
    end
    if (n == 0) begin
      e.result = rm; e.carry = cin; e.lat = 1;
      return e;
    end
    case (ty)
      2'b00: begin
        if (n < 32)       begin e.result = rm << n; e.carry = rm[32 - n]; end
        else if (n == 32) begin e.result = 32'd0;   e.carry = rm[0];      end
        else              begin e.result = 32'd0;   e.carry = 1'b0;       end
        e.lat = ((n > 33) ? 33 : n) + 1;
      end
      2'b01: begin
        if (n < 32)       begin e.result = rm >> n; e.carry = rm[n - 1]; end
        else if (n == 32) begin e.result = 32'd0;   e.carry = rm[31];    end
        else              begin e.result = 32'd0;   e.carry = 1'b0;      end
        e.lat = ((n > 33) ? 33 : n) + 1;
      end
      2'b10: begin
        if (n < 32) begin e.result = 32'($signed(rm) >>> n); e.carry = rm[n - 1]; end
        else        begin e.result = {32{rm[31]}};           e.carry = rm[31];    end
        e.lat = ((n > 32) ? 32 : n) + 1;
      end
      default: begin
        m = n % 32;
        if (m == 0) begin
          e.result = rm; e.carry = rm[31]; e.lat = 33;
        end else begin
          e.result = (rm >> m) | (rm << (32 - m)); e.carry = e.result[31]; e.lat = m + 1;
        end
      end
    endcase
    return e;
  endfunction

  task automatic drive(input bit imm, input logic [11:0] sop, input logic [31:0] rm,
                       input logic [7:0] rs, input bit cin);
    bus.op_imm     = imm;
    bus.shifter_op = sop;
    bus.rm_value   = rm;
    bus.rs_value   = rs;
    bus.carry_in   = cin;
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run_op(input string tag, input bit imm, input logic [11:0] sop,
                        input logic [31:0] rm, input logic [7:0] rs, input bit cin);
    exp_t e;
    int   lat;
    sb.push_back(model(imm, sop, rm, rs, cin));
    drive(imm, sop, rm, rs, cin);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, bus.busy, 1'b1);
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    check({tag, "_done"}, bus.done, 1'b1);
    check({tag, "_result"}, bus.result, e.result);
    check({tag, "_carry"}, bus.carry_out, e.carry);
    check({tag, "_latency"}, lat, e.lat);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    exp_t e;
    int   dones;
    logic [31:0] first_res;
    logic        first_c;

    bus.start = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 12'h000, 32'h0, 8'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", bus.result, 32'h0);
    check("rst_carry", bus.carry_out, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("imm_1ff",  1'b1, 12'h1FF, 32'h0,          8'd0,   1'b0);
    run_op("lsl0",     1'b0, 12'h000, 32'h80000001,   8'd0,   1'b0);
    run_op("lsr32",    1'b0, 12'h020, 32'h80000000,   8'd0,   1'b0);
    run_op("lsl_rs33", 1'b0, 12'h010, 32'hFFFFFFFF,   8'd33,  1'b1);
    run_op("asr_rs200",1'b0, 12'h050, 32'h80000000,   8'd200, 1'b0);
    run_op("rrx",      1'b0, 12'h060, 32'h00000003,   8'd0,   1'b1);
    run_op("ror_rs32", 1'b0, 12'h070, 32'h80000001,   8'd32,  1'b0);
    run_op("rs_zero",  1'b0, 12'h030, 32'h12345678,   8'd0,   1'b1);
    run_op("lsr_rs40", 1'b0, 12'h030, 32'hFFFFFFFF,   8'd40,  1'b0);

    for (int i = 0; i < 16; i++) begin
      run_op("rand", 1'($urandom_range(0, 1)), 12'($urandom), $urandom,
             8'($urandom), 1'($urandom_range(0, 1)));
    end

    // A second start during SHIFT is dropped: only one done, for the first op.
    run_op("pre_ign", 1'b1, 12'h1FF, 32'h0, 8'd0, 1'b0);
    sb.push_back(model(1'b0, 12'h020, 32'h80000000, 8'd0, 1'b0));
    drive(1'b0, 12'h020, 32'h80000000, 8'd0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    drive(1'b0, 12'h000, 32'h5A5A5A5A, 8'd0, 1'b1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    first_res = 32'h0;
    first_c = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (bus.done) begin
        if (dones == 0) begin
          first_res = bus.result;
          first_c = bus.carry_out;
        end
        dones++;
      end
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    check("ign_dones", dones, 1);
    check("ign_result", first_res, e.result);
    check("ign_carry", first_c, e.carry);

    // Start during the DONE cycle is ignored.
    sb.push_back(model(1'b1, 12'h1FF, 32'h0, 8'd0, 1'b0));
    drive(1'b1, 12'h1FF, 32'h0, 8'd0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 40 && !bus.done; i++) begin
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    check("dn_done", bus.done, 1'b1);
    check("dn_result", bus.result, e.result);
    drive(1'b0, 12'h000, 32'h11111111, 8'd0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("dn_start_ignored", bus.busy, 1'b0);
    @(posedge clk); #1;
    check("dn_still_idle", bus.busy, 1'b0);
    check("dn_result_held", bus.result, 32'hC000003F);

    // Flush in the fifth SHIFT cycle aborts with no done and keeps the result.
    drive(1'b0, 12'h020, 32'h80000000, 8'd0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("fl_busy", bus.busy, 1'b0);
    check("fl_done", bus.done, 1'b0);
    check("fl_result", bus.result, 32'hC000003F);
    check("fl_carry", bus.carry_out, 1'b1);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("fl_no_done", dones, 0);

    // Flush and start together in IDLE: the start is dropped.
    drive(1'b0, 12'h000, 32'h22222222, 8'd0, 1'b0);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("fl_start_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    check("fl_start_done", bus.done, 1'b0);
    check("fl_start_result", bus.result, 32'hC000003F);

    // Reset mid-SHIFT clears the outputs asynchronously, before any clock edge.
    run_op("pre_rst", 1'b0, 12'h050, 32'h80000000, 8'd200, 1'b0);
    drive(1'b0, 12'h020, 32'h80000000, 8'd0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_result", bus.result, 32'h0);
    check("arst_carry", bus.carry_out, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 1'b0, 12'h060, 32'h00000003, 8'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
